// File: rtl/ling_mp_adder_pkg.sv
// Shared definitions for the byte-serial multi-precision adder.
//   BYTE_W    : width of one adder-core slice
//   state_e   : sequencer states (IDLE=0, RUN=1, DONE=2)
//   idx_width : width of a byte-index counter for n bytes (minimum 1)
package ling_mp_adder_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ling8_core.sv
// Combinational 8-bit adder with carry-in, built on Ling pseudo-carries.
//   a_i, b_i : addends
//   cin_i    : carry into bit 0
//   sum_o    : (a_i + b_i + cin_i) mod 256
//   cout_o   : carry out of bit 7
module ling8_core
  import ling_mp_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);

  // Ling recurrence: h[i+1] = g[i] | c[i], so c[i] = t[i-1] & h[i] and
  // h[i+1] = g[i] | (t[i-1] & h[i]). The pseudo-carry h drops one AND term
  // from each level compared with the plain carry chain.
  function automatic logic [BYTE_W:0] ling_add(input logic [BYTE_W-1:0] x,
                                               input logic [BYTE_W-1:0] y,
                                               input logic              ci);
    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] t;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   h;
    logic [BYTE_W:0]   c;
    g    = x & y;
    t    = x | y;
    p    = x ^ y;
    h    = '0;
    c    = '0;
    c[0] = ci;
    h[1] = g[0] | ci;
    c[1] = t[0] & h[1];
    for (int i = 1; i < BYTE_W; i++) begin
      h[i+1] = g[i] | (t[i-1] & h[i]);
      c[i+1] = t[i] & h[i+1];
    end
    return {c[BYTE_W], p ^ c[BYTE_W-1:0]};
  endfunction

  logic [BYTE_W:0] res;

  assign res    = ling_add(a_i, b_i, cin_i);
  assign sum_o  = res[BYTE_W-1:0];
  assign cout_o = res[BYTE_W];

endmodule

// File: rtl/ling_mp_adder.sv
// Byte-serial multi-precision adder/subtractor. Operands are latched on the
// input handshake, then fed one byte per cycle (LSB first) through a single
// ling8_core with the inter-byte carry held in a register.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (accepted only in IDLE)
//   a, b, Cin, sub        : operands; sub=1 computes a-b and ignores Cin
//   out_valid/out_ready   : result handshake
//   sum, carry, ovf       : result, carry out of MSB, signed overflow
//   busy                  : an operation is in RUN or DONE
module ling_mp_adder
  import ling_mp_adder_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     Cin,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     carry,
  output logic                     ovf,
  output logic                     busy
);

  localparam int unsigned W    = BYTE_W * NBYTES;
  localparam int unsigned IdxW = idx_width(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              creg_q;
  logic [W-1:0]      opa_q;
  logic [W-1:0]      opb_q;
  logic [W-1:0]      sum_q;
  logic              carry_q;
  logic              ovf_q;

  logic [BYTE_W-1:0] core_a;
  logic [BYTE_W-1:0] core_b;
  logic [BYTE_W-1:0] core_sum;
  logic              core_cout;

  assign core_a = opa_q[BYTE_W*idx_q +: BYTE_W];
  assign core_b = opb_q[BYTE_W*idx_q +: BYTE_W];

  ling8_core u_core (
    .a_i   (core_a),
    .b_i   (core_b),
    .cin_i (creg_q),
    .sum_o (core_sum),
    .cout_o(core_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      creg_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            opa_q   <= a;
            // Subtraction is a + ~b + 1: invert B here, inject the +1 as carry-in.
            opb_q   <= sub ? ~b : b;
            creg_q  <= sub ? 1'b1 : Cin;
            idx_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[BYTE_W*idx_q +: BYTE_W] <= core_sum;
          creg_q <= core_cout;
          idx_q  <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            carry_q <= core_cout;
            // Same-sign operands producing a result of the other sign.
            ovf_q   <= (opa_q[W-1] == opb_q[W-1]) && (core_sum[BYTE_W-1] != opa_q[W-1]);
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ling_mp_adder.sv
module tb_ling_mp_adder;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;
  logic         busy;

  int n_checks;
  int n_fails;

  ling_mp_adder #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .Cin      (Cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sb, output logic [W-1:0] s, output logic c,
                       output logic o);
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned full;
    longint          sx;
    longint          sy;
    longint          r;
    longint          smax;
    longint          smin;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (sb) begin
      s = W'(ux - uy);
      c = (ux >= uy);
      r = sx - sy;
    end else begin
      full = ux + uy + longint'(ci);
      s    = W'(full);
      c    = full[W];
      r    = sx + sy + longint'(ci);
    end
    o = (r > smax) || (r < smin);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, input int hold);
    logic [W-1:0] es;
    logic [W-1:0] mask;
    logic         ec;
    logic         eo;
    int           lat;
    bit           seen;
    model(ta, tb_v, tcin, tsub, es, ec, eo);
    @(negedge clk);
    chk("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    Cin      = tcin;
    sub      = tsub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    Cin      = 1'($urandom);
    sub      = 1'($urandom);
    lat      = 0;
    seen     = 1'b0;
    while (!seen && lat < 3 * NBYTES + 4) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) begin
        seen = 1'b1;
      end else if (lat < NBYTES) begin
        mask = '0;
        for (int k = 0; k < lat; k++) mask[8*k +: 8] = 8'hFF;
        chk("partial_sum", sum, es & mask);
      end
    end
    chk("out_valid_seen", W'(seen), W'(1));
    chk("latency", W'(lat), W'(NBYTES));
    chk("sum", sum, es);
    chk("carry", W'(carry), W'(ec));
    chk("ovf", W'(ovf), W'(eo));
    chk("busy_done", W'(busy), W'(1));
    chk("in_ready_done", W'(in_ready), W'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_sum", sum, es);
      chk("hold_carry", W'(carry), W'(ec));
      chk("hold_ovf", W'(ovf), W'(eo));
      chk("hold_in_ready", W'(in_ready), W'(0));
    end
    // in_valid held high across the release edge must not start a new op.
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("release_valid", W'(out_valid), W'(0));
    chk("release_busy", W'(busy), W'(0));
    chk("release_in_ready", W'(in_ready), W'(1));
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    Cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum", sum, '0);
    chk("rst_carry", W'(carry), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(in_ready), W'(1));

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
    run_op(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 0);
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 10);

    // Abort during RUN once bytes 0 and 1 are done.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hAAAA_AAAA;
    b        = 32'h5555_5555;
    Cin      = 1'b1;
    sub      = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", W'(in_ready), W'(0));
    chk("abort_sum", sum, '0);
    chk("abort_carry", W'(carry), W'(0));
    chk("abort_ovf", W'(ovf), W'(0));
    chk("abort_busy_clr", W'(busy), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_rel", W'(in_ready), W'(1));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", W'(out_valid), W'(0));
    end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
